// File: rtl/systolic_scheduler.sv
// Control sequencer for a ROWS x COLS weight-stationary systolic array:
// one-hot weight load, skewed multiply wavefront over K vectors, column drain.
module systolic_scheduler #(
  parameter int ROWS        = 2,
  parameter int COLS        = 2,
  parameter int MAX_K       = 16,
  parameter int STEP_CYCLES = 4,
  parameter int K_W         = $clog2(MAX_K + 1),
  parameter int S_W         = $clog2(MAX_K + ROWS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            general_enable,
  input  logic            start,
  input  logic [K_W-1:0]  k_len,
  input  logic            abort,
  output logic            busy,
  output logic [ROWS-1:0] load_weight,
  output logic [ROWS-1:0] enable_mult,
  output logic            step_strobe,
  output logic [S_W-1:0]  step_idx,
  output logic            done
);

  localparam int CYC_W   = $clog2(STEP_CYCLES + 1);
  localparam int DRN_LEN = COLS * STEP_CYCLES;
  localparam int DRN_W   = $clog2(DRN_LEN + 1);
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [S_W-1:0]    step_q, step_d;
  logic [DRN_W-1:0]  drain_q, drain_d;
  logic [K_W-1:0]    k_q, k_d;

  logic              busy_q, busy_d;
  logic [ROWS-1:0]   load_weight_q, load_weight_d;
  logic [ROWS-1:0]   enable_mult_q, enable_mult_d;
  logic              step_strobe_q, step_strobe_d;
  logic [S_W-1:0]    step_idx_q, step_idx_d;
  logic              done_q, done_d;

  // Outputs are registered from the next state, so they describe the cycle
  // that follows each enabled edge; a low general_enable freezes everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      row_q         <= '0;
      cyc_q         <= '0;
      step_q        <= '0;
      drain_q       <= '0;
      k_q           <= '0;
      busy_q        <= 1'b0;
      load_weight_q <= '0;
      enable_mult_q <= '0;
      step_strobe_q <= 1'b0;
      step_idx_q    <= '0;
      done_q        <= 1'b0;
    end else if (general_enable) begin
      state_q       <= state_d;
      row_q         <= row_d;
      cyc_q         <= cyc_d;
      step_q        <= step_d;
      drain_q       <= drain_d;
      k_q           <= k_d;
      busy_q        <= busy_d;
      load_weight_q <= load_weight_d;
      enable_mult_q <= enable_mult_d;
      step_strobe_q <= step_strobe_d;
      step_idx_q    <= step_idx_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cyc_d   = cyc_q;
    step_d  = step_q;
    drain_d = drain_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: begin
        if (start && (k_len != '0)) begin
          state_d = ST_LOAD;
          row_d   = '0;
          k_d     = (int'(k_len) > MAX_K) ? K_W'(MAX_K) : k_len;
        end
      end
      ST_LOAD: begin
        if (int'(row_q) == ROWS - 1) begin
          state_d = ST_COMPUTE;
          step_d  = '0;
          cyc_d   = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      ST_COMPUTE: begin
        // The last step index is K+ROWS-2 (S = K+ROWS-1 steps in total).
        if (int'(cyc_q) == STEP_CYCLES - 1) begin
          cyc_d = '0;
          if (int'(step_q) == int'(k_q) + ROWS - 2) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end else begin
            step_d = step_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (int'(drain_q) == DRN_LEN - 1) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q inside {ST_LOAD, ST_COMPUTE, ST_DRAIN})) begin
      state_d = ST_IDLE;
    end
  end

  // Row r multiplies during steps r .. r+K-1, giving the skewed wavefront.
  always_comb begin
    busy_d        = state_d inside {ST_LOAD, ST_COMPUTE, ST_DRAIN};
    load_weight_d = (state_d == ST_LOAD) ? (ROWS'(1) << row_d) : '0;
    enable_mult_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      enable_mult_d[r] = (state_d == ST_COMPUTE) && (int'(step_d) >= r) &&
                         (int'(step_d) <= r + int'(k_d) - 1);
    end
    step_strobe_d = (state_d == ST_COMPUTE) && (cyc_d == '0);
    step_idx_d    = (state_d == ST_COMPUTE) ? step_d : '0;
    done_d        = (state_d == ST_DONE);
  end

  assign busy        = busy_q;
  assign load_weight = load_weight_q;
  assign enable_mult = enable_mult_q;
  assign step_strobe = step_strobe_q;
  assign step_idx    = step_idx_q;
  assign done        = done_q;

endmodule
